uart_mmio_ctrl: RTL and testbench

UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

---
 rtl/uart_mmio_pkg.sv | 31 +++
 rtl/uart_mmio_ctrl_sync_fifo.sv | 76 +++++++
 rtl/uart_mmio_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// ---------------------------------------------------------------------------
// uart_mmio_pkg
// Shared constants for the memory-mapped UART controller:
//   - register offsets relative to the UART window base
//   - bit positions inside the line status register (LSR)
//   - TX sequencer state encoding
// ---------------------------------------------------------------------------
package uart_mmio_pkg;

   // Register offsets from BASE_ADDR
   localparam logic [31:0] OFF_DATA    = 32'h0000_0000;
   localparam logic [31:0] OFF_IER     = 32'h0000_0001;
   localparam logic [31:0] OFF_LSR     = 32'h0000_0005;
   localparam logic [31:0] OFF_CLKFREQ = 32'h0000_0100;

   // LSR bit positions
   localparam int LSR_RX_READY    = 0;
   localparam int LSR_RX_OVR      = 1;
   localparam int LSR_TX_OVF      = 2;
   localparam int LSR_TX_NOT_FULL = 5;
   localparam int LSR_TX_IDLE     = 6;

   // TX sequencer states
   typedef enum logic [1:0] {
      TX_IDLE      = 2'd0,
      TX_ISSUE     = 2'd1,
      TX_WAIT_BUSY = 2'd2,
      TX_WAIT_DONE = 2'd3
   } tx_state_t;

endpackage : uart_mmio_pkg

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head (dout) so the register file can
// return the oldest entry in the same cycle it is addressed.
//
// Parameters: WIDTH (entry width), DEPTH (entries, power of two >= 2)
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push, din  write request / data; accepted when not full, or when full
//              and a pop is taken in the same cycle
//   pop        read request; ignored when empty
//   dout       current head entry (undefined content when empty)
//   full,empty status flags
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_FULL);
   assign do_pop  = pop & ~empty;
   // A pop frees a slot in the same edge, so a full FIFO can still take a push.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr_reg];

   // Storage has no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule : sync_fifo

// File: rtl/uart_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// uart_mmio_ctrl
// Memory-mapped front end for a byte UART: TX and RX FIFOs, a line status
// register, a clock-frequency register and a small TX sequencer that feeds
// the Uart one byte at a time.
//
// Register window (offsets from BASE_ADDR):
//   0x000 DATA    read: RX head (8'hff when empty, pops on read_enable)
//                 write: push byte into TX FIFO (dropped + tx_ovf when full)
//   0x001 IER     interrupt enables [2:0] (reads 0 without the IRQ build)
//   0x005 LSR     {0, tx_idle, tx_not_full, 00, tx_ovf, rx_ovr, rx_ready};
//                 read_enable clears tx_ovf/rx_ovr
//   0x100 CLKFREQ clock frequency handed to the Uart
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   address, write_data,
//   write_enable, read_enable      core data-bus access
//   read_data, hit                 combinational read value / window hit
//   uart_data, uart_write_enable   TX byte and one-cycle start pulse
//   uart_busy                      Uart transmitter busy
//   uart_rx_data, uart_out_valid   received byte and its valid strobe
//   clk_frequency                  clock-frequency register value
//   irq                            (UART_MMIO_CTRL_IRQ_EN only) registered IRQ
//
// Build option: define UART_MMIO_CTRL_IRQ_EN to add the irq output and make
// IER writable.
// ---------------------------------------------------------------------------
module uart_mmio_ctrl
   import uart_mmio_pkg::*;
#(
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
   parameter logic [31:0] CLK_FREQ_RST = 32'h0000_ffc0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic        write_enable,
   input  logic        read_enable,
   output logic [31:0] read_data,
   output logic        hit,
   output logic [7:0]  uart_data,
   output logic        uart_write_enable,
   input  logic        uart_busy,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_out_valid,
   output logic [31:0] clk_frequency
`ifdef UART_MMIO_CTRL_IRQ_EN
   ,
   output logic        irq
`endif
);

   // ---------------- address decode ----------------
   logic sel_data, sel_ier, sel_lsr, sel_clk;

   assign sel_data = (address == (BASE_ADDR + OFF_DATA));
   assign sel_ier  = (address == (BASE_ADDR + OFF_IER));
   assign sel_lsr  = (address == (BASE_ADDR + OFF_LSR));
   assign sel_clk  = (address == (BASE_ADDR + OFF_CLKFREQ));
   assign hit      = sel_data | sel_ier | sel_lsr | sel_clk;

   // ---------------- FIFOs ----------------
   logic       tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0] tx_head;
   logic       rx_pop, rx_full, rx_empty;
   logic [7:0] rx_head;

   tx_state_t  state_reg, state_next;
   logic [1:0] wait_cnt_reg, wait_cnt_next;
   logic [7:0] uart_data_reg, uart_data_next;

   assign tx_push = write_enable & sel_data & ~tx_full;
   assign tx_pop  = (state_reg == TX_ISSUE);
   assign rx_pop  = read_enable & sel_data & ~rx_empty;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (write_data[7:0]),
      .dout  (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   // The RX FIFO itself accepts a push into a full FIFO when the same edge pops.
   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (uart_out_valid),
      .pop   (rx_pop),
      .din   (uart_rx_data),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // ---------------- status flags ----------------
   logic rx_ovr_reg, tx_ovf_reg;
   logic rx_drop, tx_drop, lsr_clear;
   logic tx_idle;
   logic [7:0] lsr;

   assign tx_drop   = write_enable & sel_data & tx_full;
   assign rx_drop   = uart_out_valid & rx_full & ~rx_pop;
   assign lsr_clear = read_enable & sel_lsr;
   assign tx_idle   = tx_empty & (state_reg == TX_IDLE) & ~uart_busy;

   // A new overflow in the clearing cycle takes priority over the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_ovr_reg <= 1'b0;
         tx_ovf_reg <= 1'b0;
      end else begin
         if (rx_drop)        rx_ovr_reg <= 1'b1;
         else if (lsr_clear) rx_ovr_reg <= 1'b0;
         if (tx_drop)        tx_ovf_reg <= 1'b1;
         else if (lsr_clear) tx_ovf_reg <= 1'b0;
      end
   end

   always_comb begin
      lsr                  = '0;
      lsr[LSR_RX_READY]    = ~rx_empty;
      lsr[LSR_RX_OVR]      = rx_ovr_reg;
      lsr[LSR_TX_OVF]      = tx_ovf_reg;
      lsr[LSR_TX_NOT_FULL] = ~tx_full;
      lsr[LSR_TX_IDLE]     = tx_idle;
   end

   // ---------------- clock-frequency register ----------------
   logic [31:0] clk_freq_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_freq_reg <= CLK_FREQ_RST;
      end else if (write_enable && sel_clk) begin
         clk_freq_reg <= write_data;
      end
   end

   assign clk_frequency = clk_freq_reg;

   // ---------------- optional interrupt ----------------
`ifdef UART_MMIO_CTRL_IRQ_EN
   logic [2:0] ier_reg;
   logic       irq_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         ier_reg <= '0;
         irq_reg <= 1'b0;
      end else begin
         if (write_enable && sel_ier) begin
            ier_reg <= write_data[2:0];
         end
         irq_reg <= (ier_reg[0] & ~rx_empty)
                  | (ier_reg[1] & tx_idle)
                  | (ier_reg[2] & (rx_ovr_reg | tx_ovf_reg));
      end
   end

   assign irq = irq_reg;
`endif

   // ---------------- read mux ----------------
   always_comb begin
      read_data = '0;
      if (sel_data) begin
         read_data = {24'h0, (rx_empty ? 8'hff : rx_head)};
      end else if (sel_ier) begin
`ifdef UART_MMIO_CTRL_IRQ_EN
         read_data = {29'h0, ier_reg};
`else
         read_data = '0;
`endif
      end else if (sel_lsr) begin
         read_data = {24'h0, lsr};
      end else if (sel_clk) begin
         read_data = clk_freq_reg;
      end
   end

   // ---------------- TX sequencer ----------------
   // The byte is latched on the way into ISSUE so uart_data is valid for the
   // whole pulse and then holds until the next issue.
   always_comb begin
      state_next     = state_reg;
      wait_cnt_next  = wait_cnt_reg;
      uart_data_next = uart_data_reg;
      case (state_reg)
         TX_IDLE: begin
            if (!tx_empty && !uart_busy) begin
               state_next     = TX_ISSUE;
               uart_data_next = tx_head;
            end
         end
         TX_ISSUE: begin
            state_next    = TX_WAIT_BUSY;
            wait_cnt_next = '0;
         end
         TX_WAIT_BUSY: begin
            // Give the Uart up to four cycles to raise busy.
            if (uart_busy || wait_cnt_reg == 2'd3) begin
               state_next = TX_WAIT_DONE;
            end else begin
               wait_cnt_next = wait_cnt_reg + 2'd1;
            end
         end
         TX_WAIT_DONE: begin
            if (!uart_busy) begin
               state_next = TX_IDLE;
            end
         end
         default: state_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= TX_IDLE;
         wait_cnt_reg  <= '0;
         uart_data_reg <= 8'hff;
      end else begin
         state_reg     <= state_next;
         wait_cnt_reg  <= wait_cnt_next;
         uart_data_reg <= uart_data_next;
      end
   end

   assign uart_write_enable = tx_pop;
   assign uart_data         = uart_data_reg;

endmodule : uart_mmio_ctrl

// File: tb/tb_uart_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_mmio_ctrl
// Directed bench for uart_mmio_ctrl (default build, FIFO_DEPTH = 8). A small
// Uart responder raises uart_busy for a programmable number of cycles after
// each start pulse and records every issued byte.
// ---------------------------------------------------------------------------
module tb_uart_mmio_ctrl;

   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam logic [31:0] A_DAT = BASE + 32'h000;
   localparam logic [31:0] A_IER = BASE + 32'h001;
   localparam logic [31:0] A_LSR = BASE + 32'h005;
   localparam logic [31:0] A_CLK = BASE + 32'h100;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        write_enable;
   logic        read_enable;
   logic [31:0] read_data;
   logic        hit;
   logic [7:0]  uart_data;
   logic        uart_write_enable;
   logic        uart_busy;
   logic [7:0]  uart_rx_data;
   logic        uart_out_valid;
   logic [31:0] clk_frequency;

   int n_checks = 0;
   int n_fail   = 0;

   // responder state
   logic [7:0] pulse_q[$];
   int         busy_len  = 3;
   logic       busy_hold = 1'b0;
   int         busy_cnt  = 0;
   int         busy_viol = 0;

   uart_mmio_ctrl #(
      .FIFO_DEPTH   (8),
      .BASE_ADDR    (BASE),
      .CLK_FREQ_RST (32'h0000_ffc0)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .address           (address),
      .write_data        (write_data),
      .write_enable      (write_enable),
      .read_enable       (read_enable),
      .read_data         (read_data),
      .hit               (hit),
      .uart_data         (uart_data),
      .uart_write_enable (uart_write_enable),
      .uart_busy         (uart_busy),
      .uart_rx_data      (uart_rx_data),
      .uart_out_valid    (uart_out_valid),
      .clk_frequency     (clk_frequency)
   );

   always #5 clk = ~clk;

   // Uart model: sample the pulse first, then update busy, all on the falling edge.
   always @(negedge clk) begin
      if (uart_write_enable) begin
         pulse_q.push_back(uart_data);
         if (uart_busy) busy_viol++;
         $display("tx pulse data=%02h busy=%0b", uart_data, uart_busy);
      end
      if (busy_hold) begin
         uart_busy = 1'b1;
         busy_cnt  = 0;
      end else if (uart_write_enable) begin
         uart_busy = 1'b1;
         busy_cnt  = busy_len;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) uart_busy = 1'b0;
      end else begin
         uart_busy = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end else begin
         $display("ok   %s = %08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mmio_write(input logic [31:0] a, input logic [31:0] d);
      address      = a;
      write_data   = d;
      write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
   endtask

   // Combinational read checked at the falling edge; pop=1 also applies the side effect.
   task automatic mmio_read(input string tag, input logic [31:0] a,
                            input logic pop, input logic [31:0] exp);
      address     = a;
      read_enable = pop;
      @(negedge clk);
      chk(tag, read_data, exp);
      tick();
      read_enable = 1'b0;
   endtask

   task automatic hit_chk(input string tag, input logic [31:0] a, input logic exp);
      address = a;
      @(negedge clk);
      chk(tag, {31'h0, hit}, {31'h0, exp});
   endtask

   task automatic rx_byte(input logic [7:0] b);
      uart_rx_data   = b;
      uart_out_valid = 1'b1;
      tick();
      uart_out_valid = 1'b0;
   endtask

   task automatic wait_pulses(input string tag, input int n, input int budget);
      int c = 0;
      while (pulse_q.size() < n && c < budget) begin
         tick();
         c++;
      end
      chk(tag, pulse_q.size(), n);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   initial begin
      address = '0; write_data = '0; write_enable = 1'b0; read_enable = 1'b0;
      uart_rx_data = '0; uart_out_valid = 1'b0; uart_busy = 1'b0;
      do_reset();

      // reset state and decode
      @(negedge clk);
      chk("rst_clkfreq", clk_frequency, 32'h0000_ffc0);
      chk("rst_uart_data", {24'h0, uart_data}, 32'h0000_00ff);
      chk("rst_uart_we", {31'h0, uart_write_enable}, 32'h0);
      mmio_read("rst_lsr", A_LSR, 1'b0, 32'h60);
      mmio_read("rst_data_empty", A_DAT, 1'b1, 32'hff);
      hit_chk("hit_data", A_DAT, 1'b1);
      hit_chk("hit_ier", A_IER, 1'b1);
      hit_chk("hit_lsr", A_LSR, 1'b1);
      hit_chk("hit_clk", A_CLK, 1'b1);
      hit_chk("hit_off2", BASE + 32'h2, 1'b0);
      hit_chk("hit_off101", BASE + 32'h101, 1'b0);
      hit_chk("hit_below", BASE - 32'h1, 1'b0);
      mmio_read("unmapped_rd", BASE + 32'h2, 1'b0, 32'h0);
      mmio_write(A_IER, 32'h7);
      mmio_read("ier_no_irq", A_IER, 1'b0, 32'h0);
      mmio_write(BASE + 32'h2, 32'hab);
      mmio_write(A_LSR, 32'hff);
      mmio_read("lsr_after_ign_wr", A_LSR, 1'b0, 32'h60);

      // two bytes, Uart idle
      pulse_q.delete();
      busy_len = 3;
      mmio_write(A_DAT, 32'h41);
      mmio_write(A_DAT, 32'h42);
      wait_pulses("tx2_count", 2, 100);
      repeat (10) tick();
      chk("tx2_pulses_total", pulse_q.size(), 2);
      chk("tx2_byte0", {24'h0, pulse_q[0]}, 32'h41);
      chk("tx2_byte1", {24'h0, pulse_q[1]}, 32'h42);
      chk("tx2_data_hold", {24'h0, uart_data}, 32'h42);
      mmio_read("tx2_lsr_idle", A_LSR, 1'b0, 32'h60);
      mmio_read("tx2_no_rx", A_DAT, 1'b0, 32'hff);

      // TX overflow with Uart held busy
      pulse_q.delete();
      busy_hold = 1'b1;
      repeat (2) tick();
      for (int i = 0; i < 9; i++) mmio_write(A_DAT, 32'h30 + i);
      mmio_read("txovf_lsr", A_LSR, 1'b1, 32'h04);
      mmio_read("txovf_lsr_clr", A_LSR, 1'b0, 32'h00);
      busy_hold = 1'b0;
      wait_pulses("txovf_count", 8, 400);
      repeat (20) tick();
      chk("txovf_pulses_total", pulse_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("txovf_byte%0d", i), {24'h0, pulse_q[i]}, 32'h30 + i);
      end
      mmio_read("txovf_lsr_done", A_LSR, 1'b0, 32'h60);

      // RX overrun
      for (int i = 0; i < 9; i++) rx_byte(8'h10 + 8'(i));
      mmio_read("rxovr_lsr", A_LSR, 1'b0, 32'h63);
      for (int i = 0; i < 8; i++) begin
         mmio_read($sformatf("rxovr_data%0d", i), A_DAT, 1'b1, 32'h10 + i);
      end
      mmio_read("rxovr_empty", A_DAT, 1'b1, 32'hff);
      mmio_read("rxovr_lsr2", A_LSR, 1'b1, 32'h62);
      mmio_read("rxovr_lsr_clr", A_LSR, 1'b0, 32'h60);

      // full RX FIFO, push and pop in the same cycle
      for (int i = 0; i < 8; i++) rx_byte(8'h20 + 8'(i));
      uart_rx_data   = 8'h55;
      uart_out_valid = 1'b1;
      mmio_read("rxsim_head", A_DAT, 1'b1, 32'h20);
      uart_out_valid = 1'b0;
      mmio_read("rxsim_lsr", A_LSR, 1'b0, 32'h61);
      for (int i = 1; i < 8; i++) begin
         mmio_read($sformatf("rxsim_data%0d", i), A_DAT, 1'b1, 32'h20 + i);
      end
      mmio_read("rxsim_last", A_DAT, 1'b1, 32'h55);
      mmio_read("rxsim_empty", A_DAT, 1'b0, 32'hff);

      // clock-frequency register
      mmio_write(A_CLK, 32'd100);
      @(negedge clk);
      chk("clkfreq_wr", clk_frequency, 32'd100);
      mmio_read("clkfreq_rd", A_CLK, 1'b0, 32'd100);
      do_reset();
      @(negedge clk);
      chk("clkfreq_rst", clk_frequency, 32'h0000_ffc0);

      // reset while waiting for the Uart, three bytes still queued
      pulse_q.delete();
      busy_len = 20;
      for (int i = 0; i < 4; i++) mmio_write(A_DAT, 32'h70 + i);
      wait_pulses("rstab_first", 1, 50);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mmio_read("rstab_lsr_busy", A_LSR, 1'b0, 32'h20);
      repeat (40) tick();
      chk("rstab_pulses", pulse_q.size(), 1);
      chk("rstab_uart_data", {24'h0, uart_data}, 32'hff);
      mmio_read("rstab_lsr", A_LSR, 1'b0, 32'h60);

      chk("busy_at_pulse", busy_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_uart_mmio_ctrl
